// File: rtl/anabellek_hakem.sv
// Round-robin arbiter sharing one main-memory port between the instruction and
// data caches, with a per-transaction timeout that aborts stalled accesses.
module anabellek_hakem #(
  parameter int unsigned ZAMAN_ASIMI = 255,
  parameter int unsigned DATA_W      = 128
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              b_istek_i,
  input  logic [31:0]       b_adres_i,
  output logic              b_musait_o,
  output logic              b_hazir_o,
  output logic [DATA_W-1:0] b_obek_o,

  input  logic              v_istek_i,
  input  logic [31:0]       v_adres_i,
  input  logic              v_oku_i,
  input  logic [DATA_W-1:0] v_veri_i,
  output logic              v_musait_o,
  output logic              v_hazir_o,
  output logic [DATA_W-1:0] v_obek_o,

  output logic              anabellek_istek_o,
  output logic [31:0]       anabellek_adres_o,
  output logic              anabellek_oku_o,
  output logic [DATA_W-1:0] anabellek_veri_o,
  input  logic              anabellek_hazir_i,
  input  logic [DATA_W-1:0] anabellek_obek_i,

  output logic              hata_o
);

  localparam int unsigned SAYAC_W = $clog2(ZAMAN_ASIMI + 1);

  typedef enum logic [1:0] {
    BOSTA         = 2'd0,
    BUYRUK_SERVIS = 2'd1,
    VERI_SERVIS   = 2'd2
  } durum_t;

  typedef enum logic {
    BUYRUK = 1'b0,
    VERI   = 1'b1
  } kazanan_t;

  durum_t               durum;
  kazanan_t             son_kazanan;
  logic [SAYAC_W-1:0]   sayac;
  logic                 musait_q;

  assign b_musait_o = musait_q;
  assign v_musait_o = musait_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum             <= BOSTA;
      son_kazanan       <= VERI;
      sayac             <= '0;
      musait_q          <= 1'b1;
      b_hazir_o         <= 1'b0;
      v_hazir_o         <= 1'b0;
      hata_o            <= 1'b0;
      b_obek_o          <= '0;
      v_obek_o          <= '0;
      anabellek_istek_o <= 1'b0;
      anabellek_adres_o <= '0;
      anabellek_oku_o   <= 1'b0;
      anabellek_veri_o  <= '0;
    end else begin
      b_hazir_o <= 1'b0;
      v_hazir_o <= 1'b0;
      hata_o    <= 1'b0;

      case (durum)
        BOSTA: begin
          // Instruction side wins when alone, or on a tie if data won last.
          if (b_istek_i && (!v_istek_i || son_kazanan == VERI)) begin
            anabellek_adres_o <= b_adres_i;
            anabellek_oku_o   <= 1'b1;
            anabellek_veri_o  <= '0;
            anabellek_istek_o <= 1'b1;
            son_kazanan       <= BUYRUK;
            sayac             <= '0;
            musait_q          <= 1'b0;
            durum             <= BUYRUK_SERVIS;
          end else if (v_istek_i) begin
            anabellek_adres_o <= v_adres_i;
            anabellek_oku_o   <= v_oku_i;
            anabellek_veri_o  <= v_veri_i;
            anabellek_istek_o <= 1'b1;
            son_kazanan       <= VERI;
            sayac             <= '0;
            musait_q          <= 1'b0;
            durum             <= VERI_SERVIS;
          end
        end

        BUYRUK_SERVIS, VERI_SERVIS: begin
          if (anabellek_hazir_i) begin
            if (durum == BUYRUK_SERVIS) begin
              b_obek_o  <= anabellek_obek_i;
              b_hazir_o <= 1'b1;
            end else begin
              v_obek_o  <= anabellek_obek_i;
              v_hazir_o <= 1'b1;
            end
            anabellek_istek_o <= 1'b0;
            musait_q          <= 1'b1;
            durum             <= BOSTA;
          end else begin
            sayac <= sayac + 1'b1;
            // Counter is about to reach the limit: abandon the access.
            if (sayac == SAYAC_W'(ZAMAN_ASIMI - 1)) begin
              hata_o            <= 1'b1;
              anabellek_istek_o <= 1'b0;
              musait_q          <= 1'b1;
              durum             <= BOSTA;
            end
          end
        end

        default: begin
          anabellek_istek_o <= 1'b0;
          musait_q          <= 1'b1;
          durum             <= BOSTA;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_anabellek_hakem.sv
// Directed bench for anabellek_hakem: single read, round-robin tie, write,
// timeout, hazir-vs-timeout race and reset in the middle of a transaction.
module tb_anabellek_hakem;

  localparam int unsigned ZA = 10;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         b_istek_i;
  logic [31:0]  b_adres_i;
  logic         b_musait_o, b_hazir_o;
  logic [127:0] b_obek_o;
  logic         v_istek_i;
  logic [31:0]  v_adres_i;
  logic         v_oku_i;
  logic [127:0] v_veri_i;
  logic         v_musait_o, v_hazir_o;
  logic [127:0] v_obek_o;
  logic         anabellek_istek_o;
  logic [31:0]  anabellek_adres_o;
  logic         anabellek_oku_o;
  logic [127:0] anabellek_veri_o;
  logic         anabellek_hazir_i;
  logic [127:0] anabellek_obek_i;
  logic         hata_o;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [127:0] A5  = {16{8'hA5}};
  localparam logic [127:0] W1  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] X1  = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] X2  = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
  localparam logic [127:0] X3  = 128'h55555555_AAAAAAAA_55555555_AAAAAAAA;
  localparam logic [127:0] X4  = 128'h0F0F0F0F_F0F0F0F0_0F0F0F0F_F0F0F0F0;

  anabellek_hakem #(.ZAMAN_ASIMI(ZA)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .b_istek_i         (b_istek_i),
    .b_adres_i         (b_adres_i),
    .b_musait_o        (b_musait_o),
    .b_hazir_o         (b_hazir_o),
    .b_obek_o          (b_obek_o),
    .v_istek_i         (v_istek_i),
    .v_adres_i         (v_adres_i),
    .v_oku_i           (v_oku_i),
    .v_veri_i          (v_veri_i),
    .v_musait_o        (v_musait_o),
    .v_hazir_o         (v_hazir_o),
    .v_obek_o          (v_obek_o),
    .anabellek_istek_o (anabellek_istek_o),
    .anabellek_adres_o (anabellek_adres_o),
    .anabellek_oku_o   (anabellek_oku_o),
    .anabellek_veri_o  (anabellek_veri_o),
    .anabellek_hazir_i (anabellek_hazir_i),
    .anabellek_obek_i  (anabellek_obek_i),
    .hata_o            (hata_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    b_istek_i = 1'b0; b_adres_i = '0;
    v_istek_i = 1'b0; v_adres_i = '0; v_oku_i = 1'b1; v_veri_i = '0;
    anabellek_hazir_i = 1'b0; anabellek_obek_i = '0;

    // Reset state
    do_reset();
    chk("rst_b_musait", b_musait_o, 1);
    chk("rst_v_musait", v_musait_o, 1);
    chk("rst_istek", anabellek_istek_o, 0);
    chk("rst_adres", anabellek_adres_o, 0);
    chk("rst_oku", anabellek_oku_o, 0);
    chk("rst_b_obek", b_obek_o, 0);
    chk("rst_hata", hata_o, 0);

    // Single read with request withdrawn right after grant
    b_istek_i = 1'b1; b_adres_i = 32'h0000_1230;
    step();
    b_istek_i = 1'b0;
    chk("rd_istek1", anabellek_istek_o, 1);
    chk("rd_adres", anabellek_adres_o, 32'h0000_1230);
    chk("rd_oku", anabellek_oku_o, 1);
    chk("rd_musait", b_musait_o, 0);
    step();
    chk("rd_istek2", anabellek_istek_o, 1);
    step();
    chk("rd_istek3", anabellek_istek_o, 1);
    anabellek_hazir_i = 1'b1; anabellek_obek_i = A5;
    step();
    anabellek_hazir_i = 1'b0;
    chk("rd_b_hazir", b_hazir_o, 1);
    chk("rd_b_obek", b_obek_o, A5);
    chk("rd_v_hazir", v_hazir_o, 0);
    chk("rd_istek_off", anabellek_istek_o, 0);
    chk("rd_musait_back", v_musait_o, 1);
    step();
    chk("rd_b_hazir_pulse", b_hazir_o, 0);

    // Tie after reset: b, then v, then b again
    do_reset();
    b_istek_i = 1'b1; b_adres_i = 32'h0000_0100;
    v_istek_i = 1'b1; v_adres_i = 32'h0000_2000; v_oku_i = 1'b1;
    step();
    chk("tie1_adres", anabellek_adres_o, 32'h0000_0100);
    anabellek_hazir_i = 1'b1; anabellek_obek_i = X1;
    step();
    anabellek_hazir_i = 1'b0;
    chk("tie1_b_hazir", b_hazir_o, 1);
    step();
    chk("tie2_adres", anabellek_adres_o, 32'h0000_2000);
    chk("tie2_istek", anabellek_istek_o, 1);
    anabellek_hazir_i = 1'b1; anabellek_obek_i = X2;
    step();
    anabellek_hazir_i = 1'b0;
    chk("tie2_v_hazir", v_hazir_o, 1);
    chk("tie2_v_obek", v_obek_o, X2);
    chk("tie2_b_obek_hold", b_obek_o, X1);
    chk("tie2_b_hazir", b_hazir_o, 0);
    step();
    chk("tie3_adres", anabellek_adres_o, 32'h0000_0100);
    b_istek_i = 1'b0; v_istek_i = 1'b0;
    anabellek_hazir_i = 1'b1; anabellek_obek_i = X3;
    step();
    anabellek_hazir_i = 1'b0;
    chk("tie3_b_obek", b_obek_o, X3);
    step();

    // Data write
    v_istek_i = 1'b1; v_adres_i = 32'h8000_0040; v_oku_i = 1'b0; v_veri_i = W1;
    step();
    v_istek_i = 1'b0;
    chk("wr_oku", anabellek_oku_o, 0);
    chk("wr_veri", anabellek_veri_o, W1);
    chk("wr_adres", anabellek_adres_o, 32'h8000_0040);
    anabellek_hazir_i = 1'b1; anabellek_obek_i = X4;
    step();
    anabellek_hazir_i = 1'b0;
    chk("wr_v_hazir", v_hazir_o, 1);
    v_oku_i = 1'b1;
    step();

    // Memory hazir while idle is ignored
    anabellek_hazir_i = 1'b1; anabellek_obek_i = A5;
    step();
    anabellek_hazir_i = 1'b0;
    chk("idle_b_hazir", b_hazir_o, 0);
    chk("idle_v_hazir", v_hazir_o, 0);
    chk("idle_v_obek", v_obek_o, X4);

    // Timeout
    b_istek_i = 1'b1; b_adres_i = 32'h0000_3000;
    step();
    b_istek_i = 1'b0;
    chk("to_istek_c1", anabellek_istek_o, 1);
    for (int i = 2; i <= ZA; i++) begin
      step();
      chk("to_wait_hata", hata_o, 0);
      chk("to_wait_istek", anabellek_istek_o, 1);
    end
    step();
    chk("to_hata", hata_o, 1);
    chk("to_b_hazir", b_hazir_o, 0);
    chk("to_musait", b_musait_o, 1);
    chk("to_istek_off", anabellek_istek_o, 0);
    step();
    chk("to_hata_pulse", hata_o, 0);

    // Hazir on the last allowed cycle beats the timeout
    b_istek_i = 1'b1;
    step();
    b_istek_i = 1'b0;
    for (int i = 2; i <= ZA; i++) step();
    anabellek_hazir_i = 1'b1; anabellek_obek_i = X2;
    step();
    anabellek_hazir_i = 1'b0;
    chk("race_b_hazir", b_hazir_o, 1);
    chk("race_hata", hata_o, 0);
    chk("race_b_obek", b_obek_o, X2);
    step();

    // Reset during a data transaction
    v_istek_i = 1'b1; v_adres_i = 32'h0000_4000;
    step();
    v_istek_i = 1'b0;
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("mrst_musait", v_musait_o, 1);
    chk("mrst_istek", anabellek_istek_o, 0);
    chk("mrst_v_hazir", v_hazir_o, 0);
    chk("mrst_hata", hata_o, 0);
    anabellek_hazir_i = 1'b1; anabellek_obek_i = X1;
    step();
    anabellek_hazir_i = 1'b0;
    chk("late_v_hazir", v_hazir_o, 0);
    chk("late_v_obek", v_obek_o, 0);
    chk("late_hata", hata_o, 0);
    step();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
